// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_controller
// Brief    : Execute-stage issue/stall/flush control, EX/MEM scoreboard and
//            per-operand forwarding selects; start / halt-drain sequencing.
// Revision : 1.0
// ============================================================================
module pipeline_controller #(
  parameter int REG_ADDR_W   = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_reg_write,
  input  logic                  dec_is_load,
  input  logic                  dec_is_halt,
  input  logic                  exe_do_branch,
  output logic                  issue,
  output logic                  stall,
  output logic                  flush,
  output logic                  kill_ex,
  output logic [1:0]            fwd1_sel,
  output logic [1:0]            fwd2_sel,
  output logic                  halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_drain_load = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
    logic                  is_halt;
  } ex_slot_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  halted_q, halted_d;
  ex_slot_t              ex_q, ex_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;

  logic run_st;
  logic branch_live;
  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic load_use;

  assign run_st      = (state_q == ST_RUN);
  assign branch_live = exe_do_branch && (state_q != ST_HALTED);

  assign ex_m1  = dec_use_rs1 && ex_q.valid && ex_q.reg_write && (ex_q.rd == dec_rs1);
  assign ex_m2  = dec_use_rs2 && ex_q.valid && ex_q.reg_write && (ex_q.rd == dec_rs2);
  assign mem_m1 = dec_use_rs1 && mem_valid_q && mem_wr_q && (mem_rd_q == dec_rs1);
  assign mem_m2 = dec_use_rs2 && mem_valid_q && mem_wr_q && (mem_rd_q == dec_rs2);

  // A load still in EX has no result yet; one bubble moves it to MEM.
  assign load_use = ex_q.is_load && (ex_m1 || ex_m2);

  assign stall   = run_st && dec_valid && load_use && !branch_live;
  assign flush   = branch_live;
  assign kill_ex = branch_live;
  assign issue   = run_st && dec_valid && !load_use && !branch_live;

  assign fwd1_sel = !issue ? 2'd0 : ex_m1 ? 2'd1 : mem_m1 ? 2'd2 : 2'd0;
  assign fwd2_sel = !issue ? 2'd0 : ex_m2 ? 2'd1 : mem_m2 ? 2'd2 : 2'd0;

  assign halted = halted_q;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = dec_rd;
      ex_d.reg_write = dec_reg_write;
      ex_d.is_load   = dec_is_load;
      ex_d.is_halt   = dec_is_halt;
    end

    // The branch shadow sits in EX now; it must not reach MEM as a producer.
    mem_valid_d = ex_q.valid && !branch_live;
    mem_rd_d    = ex_q.rd;
    mem_wr_d    = ex_q.reg_write;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HALTED: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (issue && dec_is_halt) begin
          if (DRAIN_CYCLES > 1) begin
            state_d = ST_DRAIN;
            cnt_d   = c_drain_load;
          end else begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_DRAIN: begin
        if (branch_live && ex_q.valid && ex_q.is_halt) begin
          state_d = ST_RUN;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HALTED;
      cnt_q       <= '0;
      halted_q    <= 1'b1;
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
      ex_q        <= ex_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// Bench for pipeline_controller: directed hazard/halt scenarios, then random
// traffic checked against a per-cycle issue-history model.
module tb_pipeline_controller;

  localparam int REG_ADDR_W   = 4;
  localparam int DRAIN_CYCLES = 2;
  localparam int N_RAND       = 400;

  logic                  clk, rst, start;
  logic                  dec_valid, dec_use_rs1, dec_use_rs2;
  logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic                  dec_reg_write, dec_is_load, dec_is_halt, exe_do_branch;
  logic                  issue, stall, flush, kill_ex, halted;
  logic [1:0]            fwd1_sel, fwd2_sel;

  logic [8:0] obs, exp_v;
  int errors = 0;
  int checks = 0;

  // Issue history indexed by random-test cycle number.
  bit                  h_v  [0:N_RAND-1];
  bit                  h_k  [0:N_RAND-1];
  bit                  h_we [0:N_RAND-1];
  bit                  h_ld [0:N_RAND-1];
  bit                  h_hl [0:N_RAND-1];
  logic [REG_ADDR_W-1:0] h_rd [0:N_RAND-1];

  assign obs = {issue, stall, flush, kill_ex, fwd1_sel, fwd2_sel, halted};

  pipeline_controller #(
    .REG_ADDR_W   (REG_ADDR_W),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dec_valid     (dec_valid),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_use_rs1   (dec_use_rs1),
    .dec_use_rs2   (dec_use_rs2),
    .dec_rd        (dec_rd),
    .dec_reg_write (dec_reg_write),
    .dec_is_load   (dec_is_load),
    .dec_is_halt   (dec_is_halt),
    .exe_do_branch (exe_do_branch),
    .issue         (issue),
    .stall         (stall),
    .flush         (flush),
    .kill_ex       (kill_ex),
    .fwd1_sel      (fwd1_sel),
    .fwd2_sel      (fwd2_sel),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ev(input logic i, input logic s, input logic f,
                                    input logic k, input logic [1:0] a,
                                    input logic [1:0] b, input logic h);
    return {i, s, f, k, a, b, h};
  endfunction

  task automatic drive(input logic dv, input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                       input logic we, input logic ld, input logic hl);
    dec_valid = dv;  dec_rs1 = rs1; dec_use_rs1 = u1; dec_rs2 = rs2; dec_use_rs2 = u2;
    dec_rd = rd; dec_reg_write = we; dec_is_load = ld; dec_is_halt = hl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    start = 0;
    exe_do_branch = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    nop();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    rst = 0;
    start = 1;
    exe_do_branch = 1;
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %b want %b", obs, exp_v); end
    tick();
    rst = 1;
    start = 0;
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL start_under_reset: got %b want %b", obs, exp_v); end
    tick();
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halted_branch_ignored: got %b want %b", obs, exp_v); end
    tick();
    nop();
  endtask

  task automatic test_forward_ex();
    do_start();
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fwd_ex_producer: got %b want %b", obs, exp_v); end
    tick();
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 2'd1, 2'd0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fwd_ex_consumer: got %b want %b", obs, exp_v); end
    tick();
    nop();
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fwd_ex_idle: got %b want %b", obs, exp_v); end
    tick();
    tick();
  endtask

  task automatic test_forward_mem();
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
    tick();
    drive(1, 9, 1, 10, 1, 8, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fwd_mem_indep: got %b want %b", obs, exp_v); end
    tick();
    drive(1, 1, 1, 1, 1, 4, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 2'd2, 2'd2, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fwd_mem_consumer: got %b want %b", obs, exp_v); end
    tick();
    nop();
    tick();
    tick();
  endtask

  task automatic test_load_use();
    drive(1, 2, 1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(0, 1, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL load_use_stall: got %b want %b", obs, exp_v); end
    tick();
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 2'd2, 2'd0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL load_use_after_bubble: got %b want %b", obs, exp_v); end
    tick();
    nop();
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL load_use_single_stall: got %b want %b", obs, exp_v); end
    tick();
    tick();
  endtask

  task automatic test_branch();
    drive(1, 3, 1, 4, 1, 0, 0, 0, 0);
    tick();
    drive(1, 2, 1, 0, 0, 7, 1, 1, 0);
    tick();
    // Decode reads the load in EX; the flush must win over the load-use stall.
    exe_do_branch = 1;
    drive(1, 7, 1, 0, 0, 9, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(0, 0, 1, 1, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL branch_flush: got %b want %b", obs, exp_v); end
    tick();
    exe_do_branch = 0;
    drive(1, 7, 1, 7, 1, 9, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL branch_shadow_no_fwd: got %b want %b", obs, exp_v); end
    tick();
    nop();
    tick();
    tick();
  endtask

  task automatic test_halt();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_issue: got %b want %b", obs, exp_v); end
    tick();
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_drain: got %b want %b", obs, exp_v); end
    tick();
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_halted: got %b want %b", obs, exp_v); end
    tick();
    start = 1;
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_start_cycle: got %b want %b", obs, exp_v); end
    tick();
    start = 0;
    drive(1, 4, 1, 5, 1, 6, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL halt_restart_issue: got %b want %b", obs, exp_v); end
    tick();
    nop();
    tick();
    tick();
  endtask

  task automatic test_shadow_halt();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL shadow_halt_issue: got %b want %b", obs, exp_v); end
    tick();
    nop();
    exe_do_branch = 1;
    @(negedge clk);
    exp_v = ev(0, 0, 1, 1, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL shadow_halt_kill: got %b want %b", obs, exp_v); end
    tick();
    exe_do_branch = 0;
    drive(1, 2, 1, 3, 1, 4, 1, 0, 0);
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL shadow_halt_resume: got %b want %b", obs, exp_v); end
    tick();
    nop();
    tick();
    @(negedge clk);
    exp_v = ev(0, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL shadow_halt_not_halted: got %b want %b", obs, exp_v); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    drive(1, 1, 1, 2, 1, 9, 1, 0, 0);
    tick();
    // Halt that also writes r9, so the EX slot holds a live r9 producer in DRAIN.
    drive(1, 0, 0, 0, 0, 9, 1, 0, 1);
    tick();
    drive(1, 9, 1, 9, 1, 3, 1, 0, 0);
    rst = 0;
    #1;
    exp_v = ev(0, 0, 0, 0, 0, 0, 1); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_drain_reset: got %b want %b", obs, exp_v); end
    rst = 1;
    start = 1;
    tick();
    start = 0;
    @(negedge clk);
    exp_v = ev(1, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_drain_stale_slot: got %b want %b", obs, exp_v); end
    tick();
    nop();
    tick();
  endtask

  task automatic test_random();
    bit run_mode, brk, is_run, p1, p2, m1a, m1b, m2a, m2b, lu, e_iss, e_stl;
    int halt_at;
    logic [1:0] e_f1, e_f2;
    rst = 0;
    #1;
    rst = 1;
    nop();
    run_mode = 0;
    halt_at  = -1;
    for (int c = 0; c < N_RAND; c++) begin
      if (c > 0 && $urandom_range(0, 99) == 0) begin
        rst = 0;
        #1;
        rst = 1;
        run_mode = 0;
        halt_at  = -1;
        h_v[c-1] = 0;
        if (c >= 2) h_v[c-2] = 0;
      end
      start         = ($urandom_range(0, 99) < 20);
      exe_do_branch = ($urandom_range(0, 99) < 10);
      drive($urandom_range(0, 99) < 80, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4);

      // Producers one and two cycles back, unless killed as a branch shadow.
      p1  = (c >= 1) && h_v[c-1] && !h_k[c-1];
      p2  = (c >= 2) && h_v[c-2] && !h_k[c-2];
      m1a = dec_use_rs1 && p1 && h_we[c-1] && (h_rd[c-1] == dec_rs1);
      m1b = dec_use_rs2 && p1 && h_we[c-1] && (h_rd[c-1] == dec_rs2);
      m2a = dec_use_rs1 && p2 && h_we[c-2] && (h_rd[c-2] == dec_rs1);
      m2b = dec_use_rs2 && p2 && h_we[c-2] && (h_rd[c-2] == dec_rs2);
      lu     = (m1a || m1b) && h_ld[c-1];
      brk    = exe_do_branch && run_mode;
      is_run = run_mode && (halt_at < 0);
      e_stl  = is_run && dec_valid && lu && !brk;
      e_iss  = is_run && dec_valid && !lu && !brk;
      e_f1   = !e_iss ? 2'd0 : m1a ? 2'd1 : m2a ? 2'd2 : 2'd0;
      e_f2   = !e_iss ? 2'd0 : m1b ? 2'd1 : m2b ? 2'd2 : 2'd0;

      @(negedge clk);
      exp_v = ev(e_iss, e_stl, brk, brk, e_f1, e_f2, !run_mode); checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b want %b", c, obs, exp_v);
      end

      h_v[c] = e_iss;  h_k[c] = 0;  h_rd[c] = dec_rd;
      h_we[c] = dec_reg_write;  h_ld[c] = dec_is_load;  h_hl[c] = dec_is_halt;
      if (brk && c >= 1) begin
        h_k[c-1] = 1;
        if (h_v[c-1] && h_hl[c-1]) halt_at = -1;
      end
      if (e_iss && dec_is_halt) halt_at = c;
      if (!run_mode) begin
        if (start) run_mode = 1;
      end else if (halt_at >= 0 && c + 1 >= halt_at + DRAIN_CYCLES) begin
        run_mode = 0;
        halt_at  = -1;
      end
      tick();
    end
    nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    nop();
    test_reset();
    test_forward_ex();
    test_forward_mem();
    test_load_use();
    test_branch();
    test_halt();
    test_shadow_halt();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
